// File: rtl/grb_pkg.sv
//==============================================================================
// Module      : grb_pkg
// Description : Shared definitions for the GRB frame scheduler: word width,
//               scheduler state encoding, serializer reset-code timing and a
//               small grant-decoding helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package grb_pkg;

  // Width of one GRB pixel word (8 bits each of green, red, blue)
  localparam int GRB_W = 24;

  // Width of the completed-frame counter
  localparam int FRAME_CNT_W = 16;

  // Scheduler states
  typedef enum logic [2:0] {
    SIDLE    = 3'd0,
    SFETCH   = 3'd1,
    SPRESENT = 3'd2,
    SLATCH   = 3'd3,
    SRELEASE = 3'd4
  } sched_state_t;

  // Reset-code timing used by the serializer; the LED line must stay low for
  // more than 280 us, so 300 us leaves margin against clock tolerance.
  localparam int CLK_FREQ_HZ       = 50_000_000;
  localparam int RESET_CODE_US     = 300;
  localparam int RESET_CODE_CYCLES = (CLK_FREQ_HZ / 1_000_000) * RESET_CODE_US;

  // Index of the owner encoded in a one-hot two-requester grant
  function automatic logic served_index(input logic [1:0] onehot);
    return onehot[1];
  endfunction

endpackage : grb_pkg

`default_nettype wire

// File: rtl/rr_arb2.sv
//==============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin selector. Purely combinational;
//               on a tie the requester that was not served last wins.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       lastServed,
  output logic [1:0] winner
);

  // Single requester wins outright; a tie goes to the one not served last
  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = lastServed ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/grb_frame_sched.sv
//==============================================================================
// Module      : grb_frame_sched
// Description : Frame scheduler for a GRB LED serializer. Arbitrates two
//               frame sources round-robin, walks the owner's pixels one word
//               at a time, then requests the latch/reset code.
//               Optional macro GRB_SCHED_FRAME_CNT_EN enables the 16-bit
//               completed-frame counter; otherwise frameCount is tied to 0.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module grb_frame_sched
  import grb_pkg::*;
#(
  parameter int NPIX   = 8,
  parameter int NPIX_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req,
  output logic [1:0]             grant,
  input  logic [GRB_W-1:0]       pixData0,
  input  logic [GRB_W-1:0]       pixData1,
  output logic [NPIX_W-1:0]      pixAddr,
  output logic [GRB_W-1:0]       grbWord,
  output logic                   wordValid,
  input  logic                   wordTaken,
  output logic                   latchReq,
  input  logic                   allDone,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frameCount
);

  localparam logic [NPIX_W-1:0] LAST_ADDR = NPIX_W'(NPIX - 1);

  sched_state_t state;
  logic         lastServed;
  logic [1:0]   winner;

  rr_arb2 u_arb (
    .req        (req),
    .lastServed (lastServed),
    .winner     (winner)
  );

  // Frame sequencing: grant, fetch/present each pixel, latch, release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SIDLE;
      grant      <= 2'b00;
      pixAddr    <= '0;
      grbWord    <= '0;
      wordValid  <= 1'b0;
      latchReq   <= 1'b0;
      lastServed <= 1'b1;
    end else begin
      case (state)
        SIDLE: begin
          if (req != 2'b00) begin
            grant   <= winner;
            pixAddr <= '0;
            state   <= SFETCH;
          end
        end
        SFETCH: begin
          grbWord   <= grant[1] ? pixData1 : pixData0;
          wordValid <= 1'b1;
          state     <= SPRESENT;
        end
        SPRESENT: begin
          if (wordTaken) begin
            wordValid <= 1'b0;
            if (pixAddr == LAST_ADDR) begin
              latchReq <= 1'b1;
              state    <= SLATCH;
            end else begin
              pixAddr <= pixAddr + NPIX_W'(1);
              state   <= SFETCH;
            end
          end
        end
        SLATCH: begin
          if (allDone) begin
            latchReq <= 1'b0;
            state    <= SRELEASE;
          end
        end
        SRELEASE: begin
          grant      <= 2'b00;
          lastServed <= served_index(grant);
          state      <= SIDLE;
        end
        default: begin
          grant     <= 2'b00;
          wordValid <= 1'b0;
          latchReq  <= 1'b0;
          state     <= SIDLE;
        end
      endcase
    end
  end

  assign busy = (state != SIDLE);

`ifdef GRB_SCHED_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;

  // Count completed frames, wrapping at the counter width
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (state == SRELEASE) begin
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign frameCount = frame_cnt;
`else
  assign frameCount = '0;
`endif

endmodule : grb_frame_sched

`default_nettype wire

// File: doc/grb_frame_sched.md
GRB_FRAME_SCHED -- requirements
Module: grb_frame_sched

Interface
REQ-001 Parameter NPIX, default 8: pixels per frame; SHALL be >= 2.
REQ-002 Parameter NPIX_W, default 3: pixAddr width; SHALL satisfy 2**NPIX_W >= NPIX.
REQ-003 Port clk, input, 1: single system clock; all state SHALL change on posedge clk only, except on reset.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port req, input, 2: frame request; bit i belongs to requester i.
REQ-006 Port grant, output, 2: one-hot frame ownership; SHALL be all-zero when no requester owns the frame.
REQ-007 Port pixData0 / pixData1, input, 24 each: GRB word of requester 0 / 1 at pixAddr; SHALL be combinationally valid in the same cycle as pixAddr.
REQ-008 Port pixAddr, output, NPIX_W: current pixel index.
REQ-009 Port grbWord, output, 24: registered GRB word to the serializer.
REQ-010 Port wordValid, output, 1: grbWord is valid and waiting for the serializer.
REQ-011 Port wordTaken, input, 1: one-cycle pulse from the serializer; the word has been accepted.
REQ-012 Port latchReq, output, 1: all pixels are sent; serializer SHALL send the >280 us reset code.
REQ-013 Port allDone, input, 1: one-cycle pulse from the serializer; the reset code is finished.
REQ-014 Port busy, output, 1: high in every state except SIDLE.
REQ-015 Port frameCount, output, 16: count of completed frames (see Configuration).

Function
REQ-016 States SHALL be SIDLE, SFETCH, SPRESENT, SLATCH, SRELEASE, registered, with a default arm going to SIDLE.
REQ-017 SIDLE -> SFETCH when req != 0; grant SHALL be loaded with the winner and pixAddr with 0 on the same edge.
REQ-018 Arbitration SHALL be round-robin: on a simultaneous request, the requester not served last wins; after reset, requester 0 wins first.
REQ-019 SFETCH lasts 1 cycle: grbWord <= selected pixDataN; state -> SPRESENT.
REQ-020 SPRESENT: wordValid = 1; if wordTaken and pixAddr == NPIX-1 -> SLATCH; if wordTaken otherwise, pixAddr += 1 -> SFETCH.
REQ-021 SLATCH: latchReq = 1; on allDone -> SRELEASE.
REQ-022 SRELEASE lasts 1 cycle: grant <= 0, lastServed updated, frameCount += 1 (wraps 0xFFFF -> 0); state -> SIDLE.
REQ-023 Latency: req sampled at edge n gives grant high after edge n, and wordValid high after edge n+1.
REQ-024 Once granted, a frame SHALL run to completion even if req drops; no preemption.
REQ-025 wordTaken outside SPRESENT and allDone outside SLATCH SHALL be ignored.
REQ-026 wordValid, latchReq and grant SHALL be registered; wordValid and latchReq SHALL never be high together.
REQ-027 pixAddr SHALL never exceed NPIX-1; it holds its value in SLATCH, SRELEASE and SIDLE.

Reset
REQ-028 While reset is low: state = SIDLE, grant = 0, pixAddr = 0, grbWord = 0, wordValid = 0, latchReq = 0, busy = 0, frameCount = 0, lastServed = 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with no pending state kept; the first post-reset grant SHALL go to requester 0 if it requests.

Configuration
REQ-030 Macro GRB_SCHED_FRAME_CNT_EN defined: frameCount is implemented per REQ-022.
REQ-031 Macro GRB_SCHED_FRAME_CNT_EN undefined: frameCount SHALL be tied to 0 and no counter flops SHALL be inferred; all other behaviour is identical.

Structure
REQ-032 Shared package grb_pkg SHALL hold the state encodings, GRB_W = 24, and the reset-code timing constants used by the serializer.
REQ-033 Round-robin selection SHALL live in sub-module rr_arb2 (inputs req[1:0] and lastServed; output one-hot winner), which is purely combinational.

Verification
REQ-034 Reset then req = 2'b01, NPIX = 8, wordTaken pulsed 3 cycles after each wordValid rise -> grant = 01; 8 words equal to pixData0[addr 0..7] in order; latchReq after the 8th; allDone -> grant = 0 and frameCount = 1.
REQ-035 req = 2'b11 held for 3 frames -> grant sequence 01, 10, 01.
REQ-036 req0 drops after pixel 2 -> frame still ships all 8 pixels.
REQ-037 Spurious wordTaken in SLATCH and spurious allDone in SPRESENT -> no state change; pixAddr is unchanged.
REQ-038 reset pulsed low in SPRESENT at pixAddr = 5 -> all outputs at reset values within the same cycle; next req = 2'b11 grants requester 0.
REQ-039 frameCount preloaded/forced to 0xFFFF, one more frame -> frameCount = 0; with the macro undefined, frameCount stays 0 throughout.
